// File: rtl/si_dac_serializer.sv
// ---------------------------------------------------------------------------
// si_dac_serializer
//   Transmit side of the SI_DAC serial link. It accepts parallel samples over a
//   valid/ready handshake into a holding register and shifts each sample out
//   MSB first on SI. While one sample is shifting, the next one can wait in the
//   holding register, so a continuously fed stream has no bubbles between
//   frames.
//
// Parameters
//   WIDTH    sample width in bits (>=2)
//   CLK_DIV  clk cycles per serial bit (>=1); SI_en is high on the first cycle
//   GAP      idle clk cycles between the last-bit period and the next frame
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous reset, active-high; aborts any frame in progress
//   din         parallel sample, unsigned
//   din_valid   din is valid
//   din_ready   holding register can accept a sample this cycle
//   SI          serial data, MSB first, forced to 0 outside valid bits
//   SI_en       SI carries a valid bit in this cycle
//   soc         start of frame, high with SI_en on the MSB
//   busy        serializer is not idle
//   frame_done  1-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module si_dac_serializer #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             SI,
  output logic             SI_en,
  output logic             soc,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW = ($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             frame_done_q, frame_done_d;

  logic             accept;
  logic             load;
  logic             end_act;
  logic             si_en_w;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      gap_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      frame_done_q <= frame_done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    div_d        = div_q;
    gap_d        = gap_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    end_act      = 1'b0;

    accept = din_valid && !rst && !hold_full_q;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q != '0) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            bit_d   = bit_q - 1'b1;
          end else if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_INIT;
          end else begin
            end_act = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          end_act = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A waiting sample starts the next frame directly, with no idle cycle.
    if (end_act) begin
      if (hold_full_q) begin
        load = 1'b1;
      end else begin
        state_d      = ST_IDLE;
        frame_done_d = 1'b1;
      end
    end

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      bit_d       = BIT_LAST;
      div_d       = '0;
      state_d     = ST_SHIFT;
    end

    // Accept needs an empty holding register, so it never overlaps a load.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (registers only, except the ready handshake)
  // -------------------------------------------------------------------------
  always_comb begin
    din_ready  = !rst && !hold_full_q;
    si_en_w    = (state_q == ST_SHIFT) && (div_q == '0);
    SI_en      = si_en_w;
    SI         = si_en_w && shift_q[WIDTH-1];
    soc        = si_en_w && (bit_q == BIT_LAST);
    busy       = (state_q != ST_IDLE);
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_si_dac_serializer.sv
// ---------------------------------------------------------------------------
// tb_si_dac_serializer
//   Directed bench for si_dac_serializer. u0 uses CLK_DIV=1, GAP=2 and u1 uses
//   CLK_DIV=3, GAP=2; both share one clock. Inputs change 1 ns after a rising
//   edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_si_dac_serializer;

  logic        clk;
  logic        rst0, rst1;
  logic [11:0] din0, din1;
  logic        vld0, vld1;
  logic        rdy0, rdy1;
  logic        si0, si1;
  logic        sien0, sien1;
  logic        soc0, soc1;
  logic        busy0, busy1;
  logic        fd0, fd1;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [11:0] q[$];
  logic [11:0] shreg;
  int unsigned nbits;
  int unsigned frames;
  int unsigned acc;

  si_dac_serializer #(.WIDTH(12), .CLK_DIV(1), .GAP(2)) u0 (
    .clk(clk), .rst(rst0), .din(din0), .din_valid(vld0), .din_ready(rdy0),
    .SI(si0), .SI_en(sien0), .soc(soc0), .busy(busy0), .frame_done(fd0)
  );

  si_dac_serializer #(.WIDTH(12), .CLK_DIV(3), .GAP(2)) u1 (
    .clk(clk), .rst(rst1), .din(din1), .din_valid(vld1), .din_ready(rdy1),
    .SI(si1), .SI_en(sien1), .soc(soc1), .busy(busy1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle on u0 and reassemble any bits shifted out.
  task automatic tick_mon;
    tick;
    if (sien0) begin
      if (soc0) nbits = 0;
      shreg = {shreg[10:0], si0};
      nbits++;
      if (nbits == 12) begin
        frames++;
        if (q.size() == 0) chk("t5_frame_without_sample", q.size(), 1);
        else chk("t5_sample", shreg, q.pop_front());
        nbits = 0;
      end
    end
  endtask

  initial begin
    logic [11:0] bits;
    logic [11:0] v;
    int unsigned cnt;
    int unsigned pulses;
    logic        busy_ok;

    rst0 = 1'b1; rst1 = 1'b1;
    din0 = '0;   din1 = '0;
    vld0 = 1'b0; vld1 = 1'b0;
    shreg = '0; nbits = 0; frames = 0; acc = 0;

    // ---------------- reset state ----------------
    tick;
    tick;
    chk("rst_sien", sien0, 0);
    chk("rst_si", si0, 0);
    chk("rst_soc", soc0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_fd", fd0, 0);
    chk("rst_rdy_low", rdy0, 0);
    chk("rst_u1_busy", busy1, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("rst_rdy_high", rdy0, 1);
    chk("rst_u1_rdy", rdy1, 1);

    // ---------------- test 1: single frame 12'hA5C ----------------
    bits = 12'b1010_0101_1100;
    din0 = 12'hA5C; vld0 = 1'b1;
    tick;
    vld0 = 1'b0;
    chk("t1_rdy_held", rdy0, 0);
    chk("t1_idle_after_accept", busy0, 0);
    chk("t1_no_bit_yet", sien0, 0);
    tick;
    for (int i = 0; i < 12; i++) begin
      chk("t1_sien", sien0, 1);
      chk("t1_si", si0, bits[11-i]);
      chk("t1_soc", soc0, (i == 0) ? 1 : 0);
      chk("t1_busy", busy0, 1);
      tick;
    end
    chk("t1_gap1_sien", sien0, 0);
    chk("t1_gap1_busy", busy0, 1);
    chk("t1_gap1_fd", fd0, 0);
    tick;
    chk("t1_gap2_fd", fd0, 0);
    chk("t1_gap2_si", si0, 0);
    tick;
    chk("t1_fd", fd0, 1);
    chk("t1_fd_busy", busy0, 0);
    tick;
    chk("t1_fd_pulse", fd0, 0);

    // ---------------- test 2: back-to-back FFF, 001 ----------------
    din0 = 12'hFFF; vld0 = 1'b1;
    tick;
    din0 = 12'h001;
    chk("t2_rdy_drop1", rdy0, 0);
    tick;
    chk("t2_soc1", soc0, 1);
    chk("t2_rdy_after_load", rdy0, 1);
    tick;
    vld0 = 1'b0;
    chk("t2_rdy_drop2", rdy0, 0);
    cnt = 1;
    busy_ok = 1'b1;
    while (!soc0 && cnt < 40) begin
      if (!busy0) busy_ok = 1'b0;
      tick;
      cnt++;
    end
    chk("t2_soc_spacing", cnt, 14);
    chk("t2_busy_held", busy_ok, 1);
    v = '0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (sien0) pulses++;
      v = {v[10:0], si0};
      tick;
    end
    chk("t2_frame2_bits", pulses, 12);
    chk("t2_frame2_value", v, 12'h001);
    cnt = 0;
    while (!fd0 && cnt < 10) begin
      tick;
      cnt++;
    end
    chk("t2_frame_done", fd0, 1);

    // ---------------- test 4: reset at bit 5 with a held sample ----------------
    tick;
    din0 = 12'h5A5; vld0 = 1'b1;
    tick;
    din0 = 12'h3C3;
    tick;
    chk("t4_soc", soc0, 1);
    tick;
    vld0 = 1'b0;
    chk("t4_held", rdy0, 0);
    for (int i = 0; i < 4; i++) tick;
    chk("t4_at_bit5", sien0, 1);
    rst0 = 1'b1;
    #1;
    chk("t4_rdy_in_rst", rdy0, 0);
    tick;
    rst0 = 1'b0;
    #1;
    chk("t4_si", si0, 0);
    chk("t4_sien", sien0, 0);
    chk("t4_soc_cleared", soc0, 0);
    chk("t4_busy", busy0, 0);
    chk("t4_rdy", rdy0, 1);
    pulses = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (sien0) pulses++;
      if (busy0) busy_ok = 1'b0;
    end
    chk("t4_no_held_frame", pulses, 0);
    chk("t4_stays_idle", busy_ok, 1);

    // ---------------- test 3: CLK_DIV=3, 12'h800 ----------------
    din1 = 12'h800; vld1 = 1'b1;
    tick;
    vld1 = 1'b0;
    tick;
    for (int c = 0; c < 40; c++) begin
      chk("t3_sien", sien1, (c < 36 && (c % 3) == 0) ? 1 : 0);
      chk("t3_si", si1, (c == 0) ? 1 : 0);
      chk("t3_soc", soc1, (c == 0) ? 1 : 0);
      chk("t3_fd", fd1, (c == 38) ? 1 : 0);
      chk("t3_busy", busy1, (c < 38) ? 1 : 0);
      tick;
    end

    // ---------------- test 5: random stream with valid held ----------------
    for (int i = 0; i < 2000; i++) begin
      vld0 = 1'b1;
      din0 = 12'($urandom_range(0, 4095));
      if (rdy0) begin
        q.push_back(din0);
        acc++;
      end
      tick_mon;
    end
    vld0 = 1'b0;
    for (int i = 0; i < 100; i++) tick_mon;
    chk("t5_queue_drained", q.size(), 0);
    chk("t5_frame_count", frames, acc);
    chk("t5_enough_traffic", (acc > 100) ? 1 : 0, 1);
    chk("t5_idle_at_end", busy0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
